// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response handshake bundle between decode, the ALU and writeback.
interface alu_mc_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       sel;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out;
   logic             zero;
   logic             overflow;
   logic             carry;
   modport master (
      output in_valid, sel, data_a, data_b, out_ready,
      input  in_ready, out_valid, data_out, zero, overflow, carry
   );
   modport slave (
      input  in_valid, sel, data_a, data_b, out_ready,
      output in_ready, out_valid, data_out, zero, overflow, carry
   );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU; single-cycle arith/logic, bit-serial shifts and shift-add multiply.
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic   clk,
   input logic   rst,
   alu_mc_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
   state_e           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
   logic             zero_q, zero_d, ovf_q, ovf_d, carry_q, carry_d;
   logic [SHW:0]     cnt_q, cnt_d;
   logic             sub, arith, is_shift, is_mul, cout, ovf;
   logic [WIDTH-1:0] bx, sum, alu_res, shift_nxt, acc_nxt, calc_res;
   logic [SHW-1:0]   sh;
   assign sub      = bus.sel inside {4'd1, 4'd6, 4'd7, 4'd8};
   assign arith    = sub || bus.sel == 4'd0;
   assign is_shift = bus.sel inside {4'd9, 4'd10, 4'd11};
   assign is_mul   = bus.sel == 4'd12;
   assign sh       = bus.data_b[SHW-1:0];
   assign bx       = bus.data_b ^ {WIDTH{sub}};
   assign {cout, sum} = {1'b0, bus.data_a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
   assign ovf      = (bus.data_a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != bus.data_a[WIDTH-1]);
   always_comb begin
      alu_res = '0;
      case (bus.sel)
         4'd0, 4'd1:        alu_res = sum;
         4'd2:              alu_res = ~bus.data_a;
         4'd3:              alu_res = bus.data_a & bus.data_b;
         4'd4:              alu_res = bus.data_a | bus.data_b;
         4'd5:              alu_res = bus.data_a ^ bus.data_b;
         4'd6:              alu_res = WIDTH'(ovf ^ sum[WIDTH-1]);
         4'd7:              alu_res = WIDTH'(sum == '0);
         4'd8:              alu_res = WIDTH'(!cout);
         4'd9, 4'd10, 4'd11: alu_res = bus.data_a;
         default:           alu_res = '0;
      endcase
   end
   // a_q is the shifting operand for shifts and the multiplicand for MUL
   assign shift_nxt = op_q == 4'd9 ? a_q << 1 : {op_q == 4'd11 && a_q[WIDTH-1], a_q[WIDTH-1:1]};
   assign acc_nxt   = acc_q + (b_q[0] ? a_q : '0);
   assign calc_res  = op_q == 4'd12 ? acc_nxt : shift_nxt;
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      res_d   = res_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (bus.in_valid && bus.in_ready) begin
            op_d  = bus.sel;
            a_d   = bus.data_a;
            b_d   = bus.data_b;
            acc_d = '0;
            if (is_mul || (is_shift && sh != '0)) begin
               state_d = CALC;
               cnt_d   = is_mul ? (SHW+1)'(WIDTH) : {1'b0, sh};
            end else begin
               state_d = DONE;
               res_d   = alu_res;
               zero_d  = arith ? sum == '0 : alu_res == '0;
               ovf_d   = arith && ovf;
               carry_d = arith && cout;
            end
         end
         CALC: begin
            a_d   = op_q == 4'd12 ? a_q << 1 : shift_nxt;
            b_d   = b_q >> 1;
            acc_d = acc_nxt;
            cnt_d = cnt_q - (SHW+1)'(1);
            if (cnt_q == (SHW+1)'(1)) begin
               state_d = DONE;
               res_d   = calc_res;
               zero_d  = calc_res == '0;
               ovf_d   = 1'b0;
               carry_d = 1'b0;
            end
         end
         DONE: state_d = bus.out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end
   assign bus.in_ready  = state_q == IDLE && !rst;
   assign bus.out_valid = state_q == DONE;
   assign bus.data_out  = res_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = ovf_q;
   assign bus.carry     = carry_q;
endmodule
